// File: rtl/ts_pkg.sv
// Shared constants, FSM encoding and helpers for the EP3 transport-stream packer.
package ts_pkg;

   localparam int unsigned TS_LEN_DEFAULT = 188;
   localparam int unsigned ADDR_W         = 11;
   localparam int unsigned PKT_W          = 4;
   localparam logic [7:0]  TS_SYNC_BYTE   = 8'h47;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StCommit,
      StWaitAckLow
   } pack_state_t;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, a} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/ts_idle_timer.sv
// Idle-cycle counter: cleared by load, advanced by count, saturates and flags at TIMEOUT.
module ts_idle_timer #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic count,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (count && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == LIMIT);

endmodule

// File: rtl/ts_ep3_packer.sv
// Packs 188-byte TS packets into the EP3 IN buffer and commits whole-packet transfers.
module ts_ep3_packer
   import ts_pkg::*;
#(
   parameter int unsigned TS_LEN        = TS_LEN_DEFAULT,
   parameter int unsigned PKTS_PER_XFER = 2,
   parameter int unsigned FLUSH_TIMEOUT = 65535
) (
   input  logic              ep3_ext_clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [7:0]        ts_data,
   input  logic              ts_valid,
   input  logic              ts_start,
   output logic [ADDR_W-1:0] buf_in_addr,
   output logic [7:0]        buf_in_data,
   output logic              buf_in_wren,
   input  logic              buf_in_ready,
   output logic              buf_in_commit,
   output logic [ADDR_W-1:0] buf_in_commit_len,
   input  logic              buf_in_commit_ack,
   output logic [15:0]       stat_drop_cnt,
   output logic              stat_sync_err
);

   localparam logic [ADDR_W-1:0] TS_LEN_A  = ADDR_W'(TS_LEN);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(TS_LEN - 1);
   localparam logic [ADDR_W-1:0] XFER_LEN  = ADDR_W'(PKTS_PER_XFER * TS_LEN);
   localparam logic [PKT_W-1:0]  PKTS_LAST = PKT_W'(PKTS_PER_XFER - 1);

   pack_state_t       state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [PKT_W-1:0]  pkts_q, pkts_d;
   logic              in_pkt_q, in_pkt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              wren_q, wren_d;
   logic              commit_q, commit_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [15:0]       drop_cnt_q, drop_cnt_d;
   logic              sync_err_q, sync_err_d;

   logic [1:0] drop_inc;
   logic       accept, start, sync_ok;
   logic       timer_load, timer_count, timer_expire;

   assign accept  = ts_valid & enable;
   assign start   = accept & ts_start;
   assign sync_ok = (ts_data == TS_SYNC_BYTE);

   ts_idle_timer #(
      .TIMEOUT(FLUSH_TIMEOUT)
   ) u_idle_timer (
      .clk   (ep3_ext_clk),
      .reset (reset),
      .load  (timer_load),
      .count (timer_count),
      .expire(timer_expire)
   );

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      byte_cnt_d  = byte_cnt_q;
      pkts_d      = pkts_q;
      in_pkt_d    = in_pkt_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wren_d      = 1'b0;
      commit_d    = commit_q;
      len_d       = len_q;
      sync_err_d  = 1'b0;
      drop_inc    = 2'd0;
      timer_load  = 1'b1;
      timer_count = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (!buf_in_ready) begin
                  drop_inc = 2'd1;
               end else if (!sync_ok) begin
                  sync_err_d = 1'b1;
                  drop_inc   = 2'd1;
               end else begin
                  wren_d     = 1'b1;
                  addr_d     = base_q;
                  data_d     = ts_data;
                  byte_cnt_d = ADDR_W'(1);
                  in_pkt_d   = 1'b1;
                  state_d    = StFill;
               end
            end
         end

         StFill: begin
            timer_load  = accept;
            timer_count = !accept;
            if (start) begin
               // A start inside an unfinished packet truncates it; rewind to its base.
               if (in_pkt_q) begin
                  sync_err_d = 1'b1;
                  drop_inc   = drop_inc + 2'd1;
               end
               in_pkt_d   = 1'b0;
               byte_cnt_d = '0;
               if (!buf_in_ready) begin
                  drop_inc = drop_inc + 2'd1;
               end else if (!sync_ok) begin
                  sync_err_d = 1'b1;
                  drop_inc   = drop_inc + 2'd1;
               end else begin
                  wren_d     = 1'b1;
                  addr_d     = base_q;
                  data_d     = ts_data;
                  byte_cnt_d = ADDR_W'(1);
                  in_pkt_d   = 1'b1;
               end
            end else if (accept && in_pkt_q) begin
               wren_d = 1'b1;
               addr_d = base_q + byte_cnt_q;
               data_d = ts_data;
               if (byte_cnt_q == LAST_IDX) begin
                  base_d     = base_q + TS_LEN_A;
                  pkts_d     = pkts_q + 1'b1;
                  byte_cnt_d = '0;
                  in_pkt_d   = 1'b0;
                  if (pkts_q == PKTS_LAST) begin
                     commit_d = 1'b1;
                     len_d    = XFER_LEN;
                     state_d  = StCommit;
                  end
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end else if (!enable && in_pkt_q) begin
               in_pkt_d   = 1'b0;
               byte_cnt_d = '0;
            end else if (!accept && timer_expire) begin
               // Flush whatever complete packets we hold; a trailing partial is lost.
               in_pkt_d   = 1'b0;
               byte_cnt_d = '0;
               if (pkts_q != '0) begin
                  commit_d = 1'b1;
                  len_d    = ADDR_W'(pkts_q) * TS_LEN_A;
                  state_d  = StCommit;
               end else begin
                  state_d = StIdle;
               end
            end
         end

         StCommit: begin
            if (start) begin
               drop_inc = 2'd1;
            end
            if (buf_in_commit_ack) begin
               commit_d = 1'b0;
               state_d  = StWaitAckLow;
            end
         end

         StWaitAckLow: begin
            if (start) begin
               drop_inc = 2'd1;
            end
            if (!buf_in_commit_ack) begin
               base_d  = '0;
               addr_d  = '0;
               pkts_d  = '0;
               state_d = StIdle;
            end
         end
      endcase

      drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
   end

   always_ff @(posedge ep3_ext_clk) begin
      if (reset) begin
         state_q    <= StIdle;
         base_q     <= '0;
         byte_cnt_q <= '0;
         pkts_q     <= '0;
         in_pkt_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         wren_q     <= 1'b0;
         commit_q   <= 1'b0;
         len_q      <= '0;
         drop_cnt_q <= '0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         byte_cnt_q <= byte_cnt_d;
         pkts_q     <= pkts_d;
         in_pkt_q   <= in_pkt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wren_q     <= wren_d;
         commit_q   <= commit_d;
         len_q      <= len_d;
         drop_cnt_q <= drop_cnt_d;
         sync_err_q <= sync_err_d;
      end
   end

   assign buf_in_addr       = addr_q;
   assign buf_in_data       = data_q;
   assign buf_in_wren       = wren_q;
   // Commit must fall in the very cycle reset is raised, not one later.
   assign buf_in_commit     = commit_q & ~reset;
   assign buf_in_commit_len = len_q;
   assign stat_drop_cnt     = drop_cnt_q;
   assign stat_sync_err     = sync_err_q;

endmodule

// File: tb/tb_ts_ep3_packer.sv
// Directed bench for ts_ep3_packer: packet-level vector table plus commit/timeout/reset sequences.
module tb_ts_ep3_packer;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [7:0]  ts_data;
   logic        ts_valid;
   logic        ts_start;
   logic [10:0] buf_in_addr;
   logic [7:0]  buf_in_data;
   logic        buf_in_wren;
   logic        buf_in_ready;
   logic        buf_in_commit;
   logic [10:0] buf_in_commit_len;
   logic        buf_in_commit_ack;
   logic [15:0] stat_drop_cnt;
   logic        stat_sync_err;

   int total = 0;
   int bad   = 0;

   logic [10:0] wr_addr[$];
   logic [7:0]  wr_data[$];
   int          sync_cnt = 0;

   ts_ep3_packer #(
      .TS_LEN       (188),
      .PKTS_PER_XFER(2),
      .FLUSH_TIMEOUT(16)
   ) dut (
      .ep3_ext_clk      (clk),
      .reset            (reset),
      .enable           (enable),
      .ts_data          (ts_data),
      .ts_valid         (ts_valid),
      .ts_start         (ts_start),
      .buf_in_addr      (buf_in_addr),
      .buf_in_data      (buf_in_data),
      .buf_in_wren      (buf_in_wren),
      .buf_in_ready     (buf_in_ready),
      .buf_in_commit    (buf_in_commit),
      .buf_in_commit_len(buf_in_commit_len),
      .buf_in_commit_ack(buf_in_commit_ack),
      .stat_drop_cnt    (stat_drop_cnt),
      .stat_sync_err    (stat_sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (buf_in_wren) begin
         wr_addr.push_back(buf_in_addr);
         wr_data.push_back(buf_in_data);
      end
      if (stat_sync_err) sync_cnt++;
   end

   typedef struct {
      logic [7:0] first;
      int         n;
      logic [7:0] seed;
      logic       rdy;
      int         exp_wr;
      int         exp_sync;
      int         exp_drop;
      int         exp_addr0;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [7:0] first, input logic [7:0] seed, input int j);
      return (j == 0) ? first : 8'(seed + j);
   endfunction

   task automatic send_pkt(input logic [7:0] first, input int n, input logic [7:0] seed);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         ts_valid = 1'b1;
         ts_start = (i == 0);
         ts_data  = pat(first, seed, i);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         ts_valid = 1'b0;
         ts_start = 1'b0;
      end
   endtask

   // Checks n logged writes starting at log index ws: contiguous addresses and packet pattern.
   task automatic chk_window(input string tag, input int ws, input int n, input int addr0,
                             input logic [7:0] first, input logic [7:0] seed);
      int errs;
      errs = 0;
      if (wr_addr.size() < ws + n) begin
         errs = n;
      end else begin
         for (int j = 0; j < n; j++) begin
            if (int'(wr_addr[ws+j]) != addr0 + j) errs++;
            if (wr_data[ws+j] != pat(first, seed, j)) errs++;
         end
      end
      chk({tag, " addr/data errors"}, errs, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " wren"},     int'(buf_in_wren), 0);
      chk({tag, " addr"},     int'(buf_in_addr), 0);
      chk({tag, " data"},     int'(buf_in_data), 0);
      chk({tag, " commit"},   int'(buf_in_commit), 0);
      chk({tag, " len"},      int'(buf_in_commit_len), 0);
      chk({tag, " drop_cnt"}, int'(stat_drop_cnt), 0);
      chk({tag, " sync_err"}, int'(stat_sync_err), 0);
   endtask

   task automatic do_ack(input string tag);
      int k;
      @(posedge clk); #1;
      buf_in_commit_ack = 1'b1;
      k = 0;
      while (buf_in_commit && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " commit drops after ack"}, int'(buf_in_commit), 0);
      @(posedge clk); #1;
      buf_in_commit_ack = 1'b0;
      idle(3);
   endtask

   initial begin
      int w0, s0, nw;

      reset             = 1'b1;
      enable            = 1'b1;
      ts_data           = 8'h00;
      ts_valid          = 1'b0;
      ts_start          = 1'b0;
      buf_in_ready      = 1'b1;
      buf_in_commit_ack = 1'b0;

      // first, n, seed, ready, writes, sync pulses, drop count after, first addr
      vecs[0] = '{8'h47, 100, 8'h10, 1'b1, 100, 0, 0, 0};    // partial, left open
      vecs[1] = '{8'h47, 188, 8'h20, 1'b1, 188, 1, 1, 0};    // truncates vec0, rewinds
      vecs[2] = '{8'h00, 188, 8'h30, 1'b1, 0,   1, 2, 0};    // bad sync byte
      vecs[3] = '{8'h47, 188, 8'h40, 1'b0, 0,   0, 3, 0};    // buffer not ready
      vecs[4] = '{8'h47, 188, 8'h50, 1'b1, 188, 0, 3, 188};  // second packet fills xfer

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      for (int v = 0; v < 5; v++) begin
         w0 = wr_addr.size();
         s0 = sync_cnt;
         buf_in_ready = vecs[v].rdy;
         send_pkt(vecs[v].first, vecs[v].n, vecs[v].seed);
         idle(3);
         buf_in_ready = 1'b1;
         nw = wr_addr.size() - w0;
         chk($sformatf("vec%0d writes", v), nw, vecs[v].exp_wr);
         chk($sformatf("vec%0d sync_err pulses", v), sync_cnt - s0, vecs[v].exp_sync);
         chk($sformatf("vec%0d drop_cnt", v), int'(stat_drop_cnt), vecs[v].exp_drop);
         if (nw > 0) begin
            chk_window($sformatf("vec%0d", v), w0, vecs[v].exp_wr, vecs[v].exp_addr0,
                       vecs[v].first, vecs[v].seed);
         end
      end

      // vec4 completed the transfer: commit held, packet during commit dropped, ack late.
      chk("xfer commit high", int'(buf_in_commit), 1);
      chk("xfer commit len", int'(buf_in_commit_len), 376);
      w0 = wr_addr.size();
      send_pkt(8'h47, 188, 8'h60);
      idle(312);
      chk("commit-time writes", wr_addr.size() - w0, 0);
      chk("commit-time drop_cnt", int'(stat_drop_cnt), 4);
      chk("commit held w/o ack", int'(buf_in_commit), 1);
      do_ack("xfer");

      // Two back-to-back packets from an empty buffer.
      w0 = wr_addr.size();
      send_pkt(8'h47, 188, 8'h01);
      send_pkt(8'h47, 188, 8'h81);
      idle(3);
      chk("b2b writes", wr_addr.size() - w0, 376);
      chk_window("b2b pkt0", w0, 188, 0, 8'h47, 8'h01);
      chk_window("b2b pkt1", w0 + 188, 188, 188, 8'h47, 8'h81);
      chk("b2b commit len", int'(buf_in_commit_len), 376);
      idle(20);
      chk("b2b commit held", int'(buf_in_commit), 1);
      do_ack("b2b");

      // Single packet flushed by idle timeout.
      send_pkt(8'h47, 188, 8'h33);
      idle(10);
      chk("flush not early", int'(buf_in_commit), 0);
      idle(20);
      chk("flush commit", int'(buf_in_commit), 1);
      chk("flush len", int'(buf_in_commit_len), 188);
      do_ack("flush");

      // Enable drops mid-packet: partial discarded, earlier packet still flushed.
      send_pkt(8'h47, 188, 8'h44);
      send_pkt(8'h47, 50, 8'h55);
      @(posedge clk); #1;
      ts_valid = 1'b0;
      ts_start = 1'b0;
      enable   = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
      idle(40);
      chk("enable-drop commit", int'(buf_in_commit), 1);
      chk("enable-drop len", int'(buf_in_commit_len), 188);
      do_ack("enable-drop");

      // Reset while committing: commit falls in the same cycle.
      send_pkt(8'h47, 188, 8'h02);
      send_pkt(8'h47, 188, 8'h03);
      idle(3);
      chk("pre-reset commit", int'(buf_in_commit), 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("reset same-cycle commit", int'(buf_in_commit), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);

      // Reset at byte 50 of a packet.
      send_pkt(8'h47, 50, 8'h66);
      @(posedge clk); #1;
      reset    = 1'b1;
      ts_valid = 1'b0;
      ts_start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("mid-pkt reset");
      @(posedge clk); #1;
      reset = 1'b0;
      idle(2);
      w0 = wr_addr.size();
      send_pkt(8'h47, 188, 8'h77);
      idle(3);
      chk("post-reset writes", wr_addr.size() - w0, 188);
      chk_window("post-reset", w0, 188, 0, 8'h47, 8'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/ts_ep3_packer.md
TS_EP3_PACKER -- requirements
Module: ts_ep3_packer

Interface
REQ-001 SHALL have parameter TS_LEN, default 188, bytes per TS packet.
REQ-002 SHALL have parameter PKTS_PER_XFER, default 2, TS packets per committed transfer (range 1..10).
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 65535, idle cycles before a partial transfer is committed.
REQ-004 SHALL have port ep3_ext_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  accept TS input when high.
REQ-007 SHALL have port ts_data  in  8  TS byte.
REQ-008 SHALL have port ts_valid  in  1  ts_data valid this cycle.
REQ-009 SHALL have port ts_start  in  1  with ts_valid, marks first byte of a packet.
REQ-010 SHALL have port buf_in_addr  out  11  EP3 buffer write address.
REQ-011 SHALL have port buf_in_data  out  8  EP3 buffer write data.
REQ-012 SHALL have port buf_in_wren  out  1  EP3 buffer write strobe.
REQ-013 SHALL have port buf_in_ready  in  1  EP3 buffer free for filling.
REQ-014 SHALL have port buf_in_commit  out  1  transfer commit request.
REQ-015 SHALL have port buf_in_commit_len  out  11  committed byte count.
REQ-016 SHALL have port buf_in_commit_ack  in  1  commit accepted by USB core.
REQ-017 SHALL have port stat_drop_cnt  out  16  packets dropped, saturating.
REQ-018 SHALL have port stat_sync_err  out  1  one-cycle pulse on truncated/unsynced packet.

Function
REQ-019 SHALL implement states IDLE, FILL, COMMIT, WAIT_ACK_LOW.
REQ-020 IDLE: on ts_valid&ts_start&enable&buf_in_ready, write byte at packet base, go FILL; non-start bytes ignored.
REQ-021 FILL: each ts_valid byte written with buf_in_wren high same cycle as registered output (1-cycle latency from input), address incrementing by 1.
REQ-022 Packet complete when byte count reaches TS_LEN; packet base advances by TS_LEN.
REQ-023 ts_start before byte TS_LEN: SHALL rewind address to packet base, pulse stat_sync_err, increment stat_drop_cnt, treat byte as new packet start.
REQ-024 Start byte not 0x47: SHALL pulse stat_sync_err, drop packet (ignore bytes until next ts_start), increment stat_drop_cnt.
REQ-025 On PKTS_PER_XFER complete packets, SHALL enter COMMIT with buf_in_commit_len = PKTS_PER_XFER*TS_LEN.
REQ-026 FILL with >=1 complete packet and no ts_valid for FLUSH_TIMEOUT cycles: SHALL enter COMMIT with len = complete packets*TS_LEN; partial packet discarded.
REQ-027 COMMIT: buf_in_commit held high until buf_in_commit_ack high, then deassert, go WAIT_ACK_LOW.
REQ-028 WAIT_ACK_LOW: wait ack low, reset base/address to 0, go IDLE.
REQ-029 Packets arriving in COMMIT/WAIT_ACK_LOW or with buf_in_ready low SHALL be dropped whole, stat_drop_cnt +1 each.
REQ-030 enable falling mid-packet SHALL discard partial packet; completed packets still committed via timeout.
REQ-031 stat_drop_cnt SHALL saturate at 0xFFFF.
REQ-032 Address SHALL never exceed PKTS_PER_XFER*TS_LEN-1; no wrap within a transfer.

Reset
REQ-033 reset SHALL force IDLE, addr/data/len 0, wren 0, commit 0, drop count 0, sync_err 0, timeout counter 0.
REQ-034 reset mid-COMMIT SHALL drop commit same cycle; buffered data discarded.

Structure
REQ-035 TS_LEN, sync byte 0x47 and state encoding SHALL live in shared package ts_pkg.
REQ-036 Timeout counter SHALL be sub-module ts_idle_timer (load, count, expire).

Verification
REQ-037 Two back-to-back 188-byte packets, ready=1 -> 376 writes addr 0..375, commit len 376, held until ack.
REQ-038 ts_start at byte 100 -> sync_err pulse, drop_cnt=1, next packet written from addr 0.
REQ-039 One packet then idle FLUSH_TIMEOUT (set 16) -> commit len 188.
REQ-040 Packet during COMMIT with ack delayed 500 cycles -> drop_cnt=1, no wren.
REQ-041 Start byte 0x00 -> sync_err, packet ignored, drop_cnt=1.
REQ-042 reset asserted at byte 50 -> all outputs 0 next cycle, next packet from addr 0.
